clk_div_glitchfree: RTL and testbench
=====================================

Name: clk_div_glitchfree

Overview:
Parametrised successor to the system clock divider. It divides i_ref_clk by a run-time ratio N, with selectable duty for odd N. Ratio, duty and enable changes are applied only at divided-period boundaries, so the output clock never glitches or produces runt pulses. It feeds UART/peripheral clock domains and also provides a ref-domain tick strobe and status.

Parameters:
DIV_W, 8 (shared CLK_DIV_WIDTH), width of the ratio and counter
RST_BYPASS, 1, mode after reset release: 1 = bypass (pass-through); 0 = held low until the first valid load

Ports:
i_ref_clk  in  1  reference clock; the only clock
i_rst_n  in  1  asynchronous active-low reset
i_clk_en  in  1  divider enable; 0 requests bypass
i_div_ratio  in  DIV_W  requested ratio N; 0 or 1 requests bypass
i_odd_high  in  1  odd-N duty select: 0 gives high = floor(N/2), 1 gives high = ceil(N/2)
o_div_clk  out  1  divided clock, or i_ref_clk in bypass
o_div_tick  out  1  ref-domain strobe marking the first ref cycle of each divided high phase
o_ratio_act  out  DIV_W  currently applied ratio; 0 in bypass
o_bypass  out  1  1 while the output mux selects i_ref_clk

Behaviour:
- Reset (async, i_rst_n=0): cnt=0, clk_int=0, ratio_act=0, h_act=0, mode=bypass, sel=divided path, o_div_tick=0. o_div_clk=0 while in reset, forced regardless of sel.
- Request valid (req_ok) = i_clk_en && i_div_ratio>=2.
- Per-load high length: H = i_odd_high ? (N+1)>>1 : N>>1. H is latched together with ratio_act. N=2 gives H=1 for either i_odd_high.
- Boundary: in divide mode, the cycle where cnt==ratio_act-1; in bypass, every ref cycle. All inputs are sampled only at boundaries. Mid-period input changes are ignored.
- Divide mode, boundary with req_ok: ratio_act<=N, h_act<=H, cnt<=0, clk_int<=1, o_div_tick<=1. Back-to-back periods stay seamless across ratio changes.
- Divide mode, boundary with !req_ok: mode<=bypass, ratio_act<=0, cnt<=0, clk_int<=0. clk_int was already low in the last cycle, so the output shows one extra low half-ref-period, then follows i_ref_clk.
- Divide mode, non-boundary: cnt<=cnt+1; clk_int<=(cnt+1 < h_act), registered; o_div_tick<=0.
- Bypass, req_ok at a posedge: mode<=divide, ratio_act<=N, h_act<=H, cnt<=H, clk_int<=0. The first period starts in the low phase (N-H cycles low), then proceeds normally.
- Bypass, !req_ok: hold state; o_div_tick<=1 every cycle, since each ref edge is a divided edge.
- Output select flop sel: updated on the falling edge of i_ref_clk from mode. At that instant both ref and clk_int are low, so the switch is glitch-free. o_div_clk = sel ? i_ref_clk : clk_int. o_bypass = sel.
- RST_BYPASS=0: after reset, stay in divide-idle (clk_int=0, sel=divided) until the first req_ok. Load then follows the bypass->divide rule.
- Counter arithmetic is DIV_W bits. ratio_act-1 never underflows because ratio_act>=2 in divide mode.
- Reset asserted mid-operation: immediate return to reset values; o_div_clk drops to 0 asynchronously.
- Divided clock period = N ref cycles exactly; high = h_act, low = N-h_act.

Decomposition:
- Shared config package/macros: CLK_DIV_WIDTH default, mode encoding constants (MODE_BYPASS, MODE_DIVIDE).
- Sub-module clk_div_out_mux: holds the negedge sel flop, the reset forcing and the final clock mux. It is kept separate so synthesis and STA can constrain the mux as a clock cell.
- Counter, load logic and tick live in the top level.

Test Plan:
- Reset release with RST_BYPASS=1, en=0 -> o_div_clk mirrors i_ref_clk, o_bypass=1, o_ratio_act=0, o_div_tick=1 every cycle.
- en=1, N=4 -> first 2 ref cycles low, then a repeating pattern of 2 high / 2 low; o_div_tick=1 once per 4 cycles, aligned with high onset; o_ratio_act=4.
- N=5: i_odd_high=0 gives 2 high / 3 low; i_odd_high=1 gives 3 high / 2 low; period is 5 in both cases.
- Change N 4->6 mid-period -> current 4-cycle period completes untouched, then 3 high / 3 low; no pulse shorter than 2 ref cycles.
- From divide N=3, set ratio=1 (or en=0) -> current period finishes, then one half-ref-period low, then ref pass-through; no high runt at either transition (checked by a min-pulse-width monitor).
- Assert i_rst_n=0 mid-high phase with N=8 -> o_div_clk=0 immediately; all status outputs reset; after release, the mode set by RST_BYPASS resumes.

Source files
------------

// File: rtl/clk_div_glitchfree_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_glitchfree_pkg
// Shared configuration for the glitch-free clock divider:
//   CLK_DIV_WIDTH : default width of the ratio and period counter
//   mode_t        : divider operating mode
//                   MODE_BYPASS - output follows the reference clock
//                   MODE_DIVIDE - output is the internally divided clock
//                   MODE_IDLE   - divided path selected but held low until
//                                 the first valid ratio is loaded
// -----------------------------------------------------------------------------
package clk_div_glitchfree_pkg;

    localparam int CLK_DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_BYPASS = 2'b01,
        MODE_DIVIDE = 2'b10
    } mode_t;

endpackage

// File: rtl/clk_div_out_mux.sv
// -----------------------------------------------------------------------------
// clk_div_out_mux
// Final output clock selection for the glitch-free divider. The select flop
// is updated on the falling edge of the reference clock: at that instant both
// the reference clock and the divided clock are low (the divider only changes
// mode while its internal clock is low), so the mux input swap cannot produce
// a glitch. Kept as its own module so the mux can be constrained as a clock
// cell.
//
// Ports:
//   ref_clk  in   reference clock
//   rst_n    in   asynchronous active-low reset; forces div_clk low
//   mode     in   divider mode from the ref-domain control logic
//   clk_int  in   registered divided clock
//   div_clk  out  selected output clock
//   sel      out  1 while the reference clock is passed through
// -----------------------------------------------------------------------------
module clk_div_out_mux
    import clk_div_glitchfree_pkg::*;
(
    input  logic  ref_clk,
    input  logic  rst_n,
    input  mode_t mode,
    input  logic  clk_int,
    output logic  div_clk,
    output logic  sel
);

    always_ff @(negedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= 1'b0;
        end else begin
            sel <= (mode == MODE_BYPASS);
        end
    end

    // Reset gating keeps the output low for the whole reset interval,
    // independent of where the select flop happens to be.
    assign div_clk = rst_n & (sel ? ref_clk : clk_int);

endmodule

// File: rtl/clk_div_glitchfree.sv
// -----------------------------------------------------------------------------
// clk_div_glitchfree
// Run-time programmable clock divider. Divides i_ref_clk by N with selectable
// high length for odd N. Ratio, duty and enable are sampled only at divided
// period boundaries (every ref cycle while bypassed or idle), so the output
// never shows runt pulses. Also produces a ref-domain tick at the first ref
// cycle of every divided high phase, and status outputs.
//
// Ports:
//   i_ref_clk    in   reference clock, the only clock
//   i_rst_n      in   asynchronous active-low reset
//   i_clk_en     in   divider enable; 0 requests bypass
//   i_div_ratio  in   requested ratio N; 0 or 1 requests bypass
//   i_odd_high   in   odd-N duty: 0 -> high = floor(N/2), 1 -> ceil(N/2)
//   o_div_clk    out  divided clock, or i_ref_clk in bypass
//   o_div_tick   out  strobe on the first ref cycle of each divided high phase
//   o_ratio_act  out  ratio currently applied; 0 in bypass
//   o_bypass     out  1 while the output mux selects i_ref_clk
// -----------------------------------------------------------------------------
module clk_div_glitchfree
    import clk_div_glitchfree_pkg::*;
#(
    parameter int DIV_W      = CLK_DIV_WIDTH,
    parameter bit RST_BYPASS = 1'b1
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             i_clk_en,
    input  logic [DIV_W-1:0] i_div_ratio,
    input  logic             i_odd_high,
    output logic             o_div_clk,
    output logic             o_div_tick,
    output logic [DIV_W-1:0] o_ratio_act,
    output logic             o_bypass
);

    localparam mode_t            MODE_RESET = RST_BYPASS ? MODE_BYPASS : MODE_IDLE;
    localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO        = DIV_W'(2);

    // High-phase length for a ratio n: (n + odd_high) >> 1, computed one bit
    // wider so n at full scale does not wrap.
    function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] n,
                                                  input logic             odd_high);
        logic [DIV_W:0] n_ext;
        n_ext = {1'b0, n} + {{DIV_W{1'b0}}, odd_high};
        return n_ext[DIV_W:1];
    endfunction

    mode_t            mode;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] ratio_act;
    logic [DIV_W-1:0] h_act;
    logic [DIV_W-1:0] req_high;
    logic             clk_int;
    logic             req_ok;
    logic             boundary;
    logic             sel;

    assign req_ok   = i_clk_en && (i_div_ratio >= TWO);
    assign req_high = high_len(i_div_ratio, i_odd_high);
    assign cnt_next = cnt + ONE;

    // ratio_act >= 2 whenever mode is MODE_DIVIDE, so ratio_act-1 cannot wrap.
    assign boundary = (mode == MODE_DIVIDE) ? (cnt == ratio_act - ONE) : 1'b1;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode       <= MODE_RESET;
            cnt        <= '0;
            ratio_act  <= '0;
            h_act      <= '0;
            clk_int    <= 1'b0;
            o_div_tick <= 1'b0;
        end else begin
            case (mode)
                MODE_DIVIDE: begin
                    if (boundary) begin
                        if (req_ok) begin
                            // Next period starts high straight away, so
                            // back-to-back periods stay seamless.
                            ratio_act  <= i_div_ratio;
                            h_act      <= req_high;
                            cnt        <= '0;
                            clk_int    <= 1'b1;
                            o_div_tick <= 1'b1;
                        end else begin
                            // clk_int is already low in the boundary cycle;
                            // the mux flips on the next falling ref edge.
                            mode       <= MODE_BYPASS;
                            ratio_act  <= '0;
                            cnt        <= '0;
                            clk_int    <= 1'b0;
                            o_div_tick <= 1'b0;
                        end
                    end else begin
                        cnt        <= cnt_next;
                        clk_int    <= (cnt_next < h_act);
                        o_div_tick <= 1'b0;
                    end
                end
                default: begin
                    if (req_ok) begin
                        // Start inside the low phase so the first divided
                        // pulse follows a full low interval of N-H cycles.
                        mode       <= MODE_DIVIDE;
                        ratio_act  <= i_div_ratio;
                        h_act      <= req_high;
                        cnt        <= req_high;
                        clk_int    <= 1'b0;
                        o_div_tick <= 1'b0;
                    end else begin
                        // In bypass every ref edge is a divided edge.
                        o_div_tick <= (mode == MODE_BYPASS);
                    end
                end
            endcase
        end
    end

    assign o_ratio_act = ratio_act;
    assign o_bypass    = sel;

    clk_div_out_mux u_out_mux (
        .ref_clk (i_ref_clk),
        .rst_n   (i_rst_n),
        .mode    (mode),
        .clk_int (clk_int),
        .div_clk (o_div_clk),
        .sel     (sel)
    );

endmodule

// File: tb/tb_clk_div_glitchfree.sv
// -----------------------------------------------------------------------------
// tb_clk_div_glitchfree
// Self-checking bench for clk_div_glitchfree. A reference model builds the
// expected output waveform one whole divided period at a time from the
// divider rules, and every ref cycle is compared in both clock halves.
// -----------------------------------------------------------------------------
module tb_clk_div_glitchfree;

    localparam int W    = 8;
    localparam int HALF = 5;

    logic         ref_clk   = 1'b0;
    logic         rst_n     = 1'b0;
    logic         clk_en    = 1'b0;
    logic         odd_high  = 1'b0;
    logic [W-1:0] div_ratio = '0;

    logic         div_clk, div_tick, bypass;
    logic [W-1:0] ratio_act;
    logic         idle_clk, idle_tick, idle_bypass;
    logic [W-1:0] idle_ratio;

    int errors = 0;
    int checks = 0;

    clk_div_glitchfree #(.DIV_W(W), .RST_BYPASS(1'b1)) u_dut (
        .i_ref_clk   (ref_clk),
        .i_rst_n     (rst_n),
        .i_clk_en    (clk_en),
        .i_div_ratio (div_ratio),
        .i_odd_high  (odd_high),
        .o_div_clk   (div_clk),
        .o_div_tick  (div_tick),
        .o_ratio_act (ratio_act),
        .o_bypass    (bypass)
    );

    clk_div_glitchfree #(.DIV_W(W), .RST_BYPASS(1'b0)) u_idle (
        .i_ref_clk   (ref_clk),
        .i_rst_n     (rst_n),
        .i_clk_en    (clk_en),
        .i_div_ratio (div_ratio),
        .i_odd_high  (odd_high),
        .o_div_clk   (idle_clk),
        .o_div_tick  (idle_tick),
        .o_ratio_act (idle_ratio),
        .o_bypass    (idle_bypass)
    );

    always #HALF ref_clk = ~ref_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: one entry per ref cycle, generated a full period at
    // a time whenever the previous period has been consumed.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic         clk;
        logic         tick;
        logic [W-1:0] ratio;
        logic         byp;
    } ent_t;

    localparam int M_BYP = 0;
    localparam int M_DIV = 1;

    ent_t q[$];
    ent_t exp_cur;
    ent_t m_e;
    logic exp_prev_byp;
    int   m_mode;
    int   m_n;
    int   m_h;
    bit   m_req;

    always @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_mode       = M_BYP;
            exp_cur      = '0;
            exp_prev_byp = 1'b0;
        end else begin
            if (q.size() == 0) begin
                m_n   = int'(div_ratio);
                m_req = clk_en && (m_n >= 2);
                m_h   = odd_high ? (m_n + 1) / 2 : m_n / 2;
                if (m_mode == M_DIV) begin
                    if (m_req) begin
                        for (int i = 0; i < m_n; i++) begin
                            m_e.clk   = (i < m_h);
                            m_e.tick  = (i == 0);
                            m_e.ratio = W'(m_n);
                            m_e.byp   = 1'b0;
                            q.push_back(m_e);
                        end
                    end else begin
                        m_e = '0;
                        m_e.byp = 1'b1;
                        q.push_back(m_e);
                        m_mode = M_BYP;
                    end
                end else if (m_req) begin
                    for (int i = 0; i < m_n - m_h; i++) begin
                        m_e = '0;
                        m_e.ratio = W'(m_n);
                        q.push_back(m_e);
                    end
                    m_mode = M_DIV;
                end else begin
                    m_e = '0;
                    m_e.tick = 1'b1;
                    m_e.byp  = 1'b1;
                    q.push_back(m_e);
                end
            end
            exp_prev_byp = exp_cur.byp;
            exp_cur      = q.pop_front();
        end
    end

    // Min-pulse-width monitor: no output pulse may be shorter than half a
    // ref period outside reset.
    time  last_edge = 0;
    logic mon_arm   = 1'b0;

    always @(negedge rst_n) mon_arm = 1'b0;

    always @(div_clk) begin
        if (mon_arm && rst_n) begin
            checks++;
            if ($time - last_edge < HALF) begin
                errors++;
                $display("FAIL min_pulse at %0t: width=%0t required>=%0d", $time, $time - last_edge, HALF);
            end
        end
        last_edge = $time;
        mon_arm   = rst_n;
    end

    // obs/exp layout: {clk_high_half, clk_low_half, tick, ratio, byp_high_half, byp_low_half}
    logic [W+4:0] obs_v, exp_v;

    task automatic run_cycle();
        logic         hc, hb, tk;
        logic [W-1:0] ra;
        @(posedge ref_clk); #1;
        hc = div_clk; hb = bypass; tk = div_tick; ra = ratio_act;
        exp_v = {(exp_prev_byp ? 1'b1 : exp_cur.clk), (exp_cur.byp ? 1'b0 : exp_cur.clk),
                 exp_cur.tick, exp_cur.ratio, exp_prev_byp, exp_cur.byp};
        @(negedge ref_clk); #1;
        obs_v = {hc, div_clk, tk, ra, hb, bypass};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge ref_clk); #1;
            checks++;
            if ({div_clk, div_tick, ratio_act, bypass} !== 11'd0) begin
                errors++;
                $display("FAIL reset_state cyc%0d got=%h want=0", i, {div_clk, div_tick, ratio_act, bypass});
            end
            checks++;
            if ({idle_clk, idle_tick, idle_ratio, idle_bypass} !== 11'd0) begin
                errors++;
                $display("FAIL reset_state_idle cyc%0d got=%h want=0", i, {idle_clk, idle_tick, idle_ratio, idle_bypass});
            end
        end
        @(negedge ref_clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL bypass_after_reset cyc%0d got=%h want=%h", i, obs_v, exp_v);
            end
            checks++;
            if ({idle_clk, idle_tick, idle_ratio, idle_bypass} !== 11'd0) begin
                errors++;
                $display("FAIL idle_hold cyc%0d got=%h want=0", i, {idle_clk, idle_tick, idle_ratio, idle_bypass});
            end
        end
    endtask

    task automatic test_div4();
        int highs, ticks;
        highs = 0; ticks = 0;
        clk_en = 1'b1; div_ratio = 8'd4; odd_high = 1'($urandom_range(0, 1));
        for (int i = 0; i < 14; i++) begin
            run_cycle();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL div4 cyc%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (i == 0) begin
                checks++;
                if ({idle_ratio, idle_bypass, idle_clk} !== {8'd4, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL idle_load got=%h want=%h", {idle_ratio, idle_bypass, idle_clk}, {8'd4, 1'b0, 1'b0});
                end
            end
            if (i >= 2) begin
                highs += int'(obs_v[W+4]);
                ticks += int'(obs_v[W+2]);
            end
        end
        checks++;
        if (highs != 6 || ticks != 3 || ratio_act !== 8'd4) begin
            errors++;
            $display("FAIL div4_pattern got highs=%0d ticks=%0d ratio=%0d want 6/3/4", highs, ticks, ratio_act);
        end
    endtask

    task automatic test_div5_odd();
        for (int od = 0; od < 2; od++) begin
            int highs, ticks;
            highs = 0; ticks = 0;
            div_ratio = 8'd5; odd_high = 1'(od);
            for (int i = 0; i < 25; i++) begin
                run_cycle();
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL div5_odd%0d cyc%0d got=%h want=%h", od, i, obs_v, exp_v);
                end
                if (i >= 15) begin
                    highs += int'(obs_v[W+4]);
                    ticks += int'(obs_v[W+2]);
                end
            end
            checks++;
            if (highs != (od == 1 ? 6 : 4) || ticks != 2) begin
                errors++;
                $display("FAIL div5_duty odd=%0d got highs=%0d ticks=%0d want %0d/2", od, highs, ticks, od == 1 ? 6 : 4);
            end
        end
    endtask

    task automatic test_ratio_change();
        bit found;
        int k;
        div_ratio = 8'd4; odd_high = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            run_cycle();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL ratio_change_pre cyc%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (i >= 10 && obs_v[W+2]) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL ratio_change_tick_wait got=no tick want=tick");
        end
        run_cycle();
        div_ratio = 8'd6;
        k = 0; found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            run_cycle();
            k++;
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL ratio_change cyc%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (obs_v[W+2]) found = 1;
        end
        checks++;
        if (k != 3 || !found) begin
            errors++;
            $display("FAIL ratio_change_old_period got=%0d cycles want=3", k);
        end
        for (int i = 0; i < 12; i++) begin
            run_cycle();
            checks++;
            if (obs_v !== exp_v || obs_v[W+1:2] !== 8'd6) begin
                errors++;
                $display("FAIL div6 cyc%0d got=%h want=%h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_to_bypass();
        bit found;
        for (int pass = 0; pass < 2; pass++) begin
            clk_en = 1'b1; div_ratio = 8'd3; odd_high = 1'b0;
            found = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                run_cycle();
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL to_bypass_pre p%0d cyc%0d got=%h want=%h", pass, i, obs_v, exp_v);
                end
                if (i >= 8 && obs_v[W+2]) found = 1;
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL to_bypass_tick_wait p%0d got=no tick want=tick", pass);
            end
            run_cycle();
            if (pass == 0) div_ratio = 8'd1;
            else           clk_en = 1'b0;
            run_cycle();
            run_cycle();
            checks++;
            if (obs_v[W+4] !== 1'b0 || obs_v[0] !== 1'b1 || obs_v[W+1:2] !== 8'd0) begin
                errors++;
                $display("FAIL to_bypass_switch p%0d got=%h want=low-half then bypass", pass, obs_v);
            end
            for (int i = 0; i < 5; i++) begin
                run_cycle();
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL to_bypass p%0d cyc%0d got=%h want=%h", pass, i, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        clk_en = 1'b1; div_ratio = 8'd8; odd_high = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            run_cycle();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_pre cyc%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (i >= 10 && obs_v[W+2]) found = 1;
        end
        @(posedge ref_clk); #2;
        checks++;
        if (!found || div_clk !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_high got=%b want=1", div_clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({div_clk, div_tick, ratio_act, bypass} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_async got=%h want=0", {div_clk, div_tick, ratio_act, bypass});
        end
        clk_en = 1'b0;
        repeat (2) @(posedge ref_clk);
        #1;
        checks++;
        if ({div_clk, div_tick, ratio_act, bypass} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_hold got=%h want=0", {div_clk, div_tick, ratio_act, bypass});
        end
        @(negedge ref_clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_resume cyc%0d got=%h want=%h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                clk_en    = ($urandom_range(0, 3) != 0);
                div_ratio = W'($urandom_range(0, 10));
                odd_high  = 1'($urandom_range(0, 1));
            end
            run_cycle();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL random cyc%0d got=%h want=%h", i, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_div5_odd();
        test_ratio_change();
        test_to_bypass();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
